// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled with mid-bit sampling; byte appears 152 ticks + 3 clocks after the start edge.
// Output holds on valid/ready; a byte that completes while the previous one is still unaccepted is dropped and flagged as overrun.
module uart_rx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int DIV = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        r_state;
  logic          r_rx_meta;
  logic          r_rx_s;
  logic [TW-1:0] r_tick_cnt;
  logic [SW-1:0] r_samp_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shreg;
  logic          r_pend;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_frame_err;
  logic          r_overrun;
  logic          r_busy;

  logic w_tick;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_tick_cnt  <= '0;
      r_samp_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shreg     <= '0;
      r_pend      <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_meta   <= i_rx;
      r_rx_s      <= r_rx_meta;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_pend      <= 1'b0;

      // Held at zero in IDLE so the first tick lands DIV clocks after start detection.
      if (r_state == S_IDLE || w_tick) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end

      // A pending byte may replace the current one only if the slot frees this cycle.
      if (r_pend) begin
        if (!r_rx_valid || i_rx_ready) begin
          r_rx_data  <= r_shreg;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun  <= 1'b1;
        end
      end else if (r_rx_valid && i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_samp_cnt <= '0;
            r_state    <= S_START;
            r_busy     <= 1'b1;
          end
        end

        S_START: begin
          if (w_tick) begin
            if (r_samp_cnt == SAMP_MID) begin
              if (r_rx_s) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_samp_cnt <= '0;
                r_bit_idx  <= '0;
                r_state    <= S_DATA;
              end
            end else begin
              r_samp_cnt <= r_samp_cnt + 1'b1;
            end
          end
        end

        S_DATA: begin
          if (w_tick) begin
            if (r_samp_cnt == SAMP_LAST) begin
              r_samp_cnt <= '0;
              r_shreg    <= {r_rx_s, r_shreg[7:1]};
              r_bit_idx  <= r_bit_idx + 1'b1;
              if (r_bit_idx == 3'd7) begin
                r_state <= S_STOP;
              end
            end else begin
              r_samp_cnt <= r_samp_cnt + 1'b1;
            end
          end
        end

        S_STOP: begin
          if (w_tick) begin
            if (r_samp_cnt == SAMP_LAST) begin
              r_samp_cnt <= '0;
              if (r_rx_s) begin
                r_pend  <= 1'b1;
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= S_BREAK;
              end
            end else begin
              r_samp_cnt <= r_samp_cnt + 1'b1;
            end
          end
        end

        S_BREAK: begin
          if (r_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_data   = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing, handshake, overrun, framing error, glitch, reset and baud tolerance.
`timescale 1ns/1ps
module tb_uart_rx;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_rx = 1'b1;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       i_rx_ready = 1'b1;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  uart_rx dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx       (i_rx),
    .o_rx_data  (o_rx_data),
    .o_rx_valid (o_rx_valid),
    .i_rx_ready (i_rx_ready),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  localparam real BIT_NOM  = 1.0e9 / 115200.0;
  localparam real BIT_SLOW = 1.0e9 / 113000.0;
  localparam real BIT_FAST = 1.0e9 / 117500.0;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vld_cycles = 0;
  int last_rise_cyc = 0;
  int fall_cyc = 0;
  logic vld_prev = 1'b0;
  logic [7:0] got_q[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  // Records every accepted byte and counts flag pulses.
  always @(negedge i_clk) begin
    if (o_frame_err) fe_cnt++;
    if (o_overrun) ov_cnt++;
    if (o_rx_valid) vld_cycles++;
    if (o_rx_valid && !vld_prev) last_rise_cyc = cyc;
    if (o_rx_valid && i_rx_ready && !i_rst) got_q.push_back(o_rx_data);
    vld_prev = o_rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] e);
    logic [7:0] b;
    if (got_q.size() == 0) begin
      check(tag, 32'h100, {24'h0, e});
    end else begin
      b = got_q.pop_front();
      check(tag, {24'h0, b}, {24'h0, e});
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input real bit_ns, input logic stop_v);
    @(posedge i_clk); #1;
    fall_cyc = cyc;
    i_rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      #(bit_ns);
    end
    i_rx = stop_v;
    #(bit_ns);
    i_rx = 1'b1;
  endtask

  task automatic check_latency(input string tag);
    int lat;
    lat = last_rise_cyc - fall_cyc - 1;
    check(tag, {31'h0, (lat >= 8210 && lat <= 8212)}, 32'h1);
  endtask

  initial begin
    int fe_base;
    int ov_base;
    int vld_base;
    logic [7:0] pat;

    repeat (5) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_data", {24'h0, o_rx_data}, 32'h00);
    check("rst_valid", {31'h0, o_rx_valid}, 32'h0);
    check("rst_ferr", {31'h0, o_frame_err}, 32'h0);
    check("rst_ovr", {31'h0, o_overrun}, 32'h0);
    check("rst_busy", {31'h0, o_busy}, 32'h0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    #(2 * BIT_NOM);

    // Three bytes with the consumer always ready.
    fe_base = fe_cnt; ov_base = ov_cnt; vld_base = vld_cycles;
    send_byte(8'h55, BIT_NOM, 1'b1);
    check_latency("lat_55");
    send_byte(8'hA3, BIT_NOM, 1'b1);
    check_latency("lat_A3");
    send_byte(8'h0D, BIT_NOM, 1'b1);
    check_latency("lat_0D");
    #(BIT_NOM);
    expect_byte("byte_55", 8'h55);
    expect_byte("byte_A3", 8'hA3);
    expect_byte("byte_0D", 8'h0D);
    check("pulse_cycles", vld_cycles - vld_base, 3);
    check("s1_ferr", fe_cnt - fe_base, 0);
    check("s1_ovr", ov_cnt - ov_base, 0);

    // Overrun: first byte held, second dropped.
    @(posedge i_clk); #1;
    i_rx_ready = 1'b0;
    ov_base = ov_cnt;
    send_byte(8'h3C, BIT_NOM, 1'b1);
    @(negedge i_clk);
    check("hold_valid", {31'h0, o_rx_valid}, 32'h1);
    check("hold_data", {24'h0, o_rx_data}, 32'h3C);
    send_byte(8'hF0, BIT_NOM, 1'b1);
    #(BIT_NOM);
    @(negedge i_clk);
    check("ovr_pulses", ov_cnt - ov_base, 1);
    check("ovr_data", {24'h0, o_rx_data}, 32'h3C);
    @(posedge i_clk); #1;
    i_rx_ready = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    check("ovr_valid_drop", {31'h0, o_rx_valid}, 32'h0);
    expect_byte("ovr_byte", 8'h3C);
    check("ovr_dropped", got_q.size(), 0);

    // Stop bit low, then recovery.
    fe_base = fe_cnt; vld_base = vld_cycles;
    send_byte(8'h81, BIT_NOM, 1'b0);
    #(2 * BIT_NOM);
    check("ferr_pulses", fe_cnt - fe_base, 1);
    check("ferr_no_valid", vld_cycles - vld_base, 0);
    send_byte(8'h7E, BIT_NOM, 1'b1);
    #(BIT_NOM);
    expect_byte("after_ferr", 8'h7E);

    // 4 us low glitch.
    fe_base = fe_cnt; vld_base = vld_cycles;
    @(posedge i_clk); #1;
    i_rx = 1'b0;
    #2000;
    check("glitch_busy", {31'h0, o_busy}, 32'h1);
    #2000;
    i_rx = 1'b1;
    #2000;
    check("glitch_idle", {31'h0, o_busy}, 32'h0);
    check("glitch_ferr", fe_cnt - fe_base, 0);
    check("glitch_valid", vld_cycles - vld_base, 0);

    // Reset during bit 4 of 8'hC3.
    fe_base = fe_cnt; ov_base = ov_cnt;
    @(posedge i_clk); #1;
    pat = 8'hC3;
    i_rx = 1'b0;
    #(BIT_NOM);
    for (int i = 0; i < 4; i++) begin
      i_rx = pat[i];
      #(BIT_NOM);
    end
    i_rx = pat[4];
    #(BIT_NOM / 2.0);
    check("pre_rst_busy", {31'h0, o_busy}, 32'h1);
    i_rst = 1'b1;
    i_rx = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("mid_rst_data", {24'h0, o_rx_data}, 32'h00);
    check("mid_rst_valid", {31'h0, o_rx_valid}, 32'h0);
    check("mid_rst_busy", {31'h0, o_busy}, 32'h0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    #(2 * BIT_NOM);
    send_byte(8'h12, BIT_NOM, 1'b1);
    #(BIT_NOM);
    expect_byte("after_rst", 8'h12);
    check("rst_q_empty", got_q.size(), 0);

    // Back-to-back frames at both edges of the baud tolerance.
    for (int i = 0; i < 10; i++) send_byte((i % 2 == 0) ? 8'hFF : 8'h00, BIT_SLOW, 1'b1);
    #(BIT_NOM);
    for (int i = 0; i < 10; i++) expect_byte("slow_b2b", (i % 2 == 0) ? 8'hFF : 8'h00);
    for (int i = 0; i < 10; i++) send_byte((i % 2 == 0) ? 8'hFF : 8'h00, BIT_FAST, 1'b1);
    #(BIT_NOM);
    for (int i = 0; i < 10; i++) expect_byte("fast_b2b", (i % 2 == 0) ? 8'hFF : 8'h00);
    check("b2b_ferr", fe_cnt - fe_base, 0);
    check("b2b_ovr", ov_cnt - ov_base, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Synthesizable UART receiver that converts the serial line from the host/bench into bytes for the sequencer core. It uses 8N1 framing, LSB first, with 16x oversampling and mid-bit sampling. It sits directly behind the top-level RX pin. Received bytes are presented on a valid/ready handshake to the command parser.

Parameters:
CLK_HZ  100000000  system clock frequency in Hz
BAUD  115200  line rate in bits/s
OVERSAMPLE  16  ticks per bit; must be even and >= 4
DIV  (CLK_HZ + BAUD*OVERSAMPLE/2)/(BAUD*OVERSAMPLE)  clocks per tick, rounded; 54 at defaults

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
rx  in  1  asynchronous serial input, idle high
rx_data  out  8  received byte, stable while rx_valid=1
rx_valid  out  1  byte available; held until accepted
rx_ready  in  1  consumer accepts when rx_valid&rx_ready
frame_err  out  1  one-cycle pulse: stop bit sampled low
overrun  out  1  one-cycle pulse: new byte completed while previous unaccepted
busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, sync flops=1, tick/bit counters=0.
- Reset mid-frame aborts the frame, discards the partial byte and clears rx_valid.
- rx passes through a 2-flop synchronizer to give rx_s; all decisions use rx_s.
- Tick generator: a counter 0..DIV-1 emits a one-cycle tick at DIV-1. It is cleared on leaving IDLE, so the first tick lands DIV cycles after start detection.
- States:
  - IDLE: on rx_s==0, clear the tick counter and sample counter, then go to START.
  - START: at tick count OVERSAMPLE/2 (mid start bit), sample rx_s. If 1, this is a false start: return to IDLE with no flags. If 0, clear the sample counter and bit index, then go to DATA.
  - DATA: every OVERSAMPLE ticks, sample rx_s and shift it in as shreg={rx_s,shreg[7:1]}. After the 8th bit, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - If 1: deliver the byte and go to IDLE.
    - If 0: pulse frame_err, discard the byte, and go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. A held-low line (break) produces exactly one frame_err.
- Delivery, on the cycle after the stop sample:
  - If rx_valid==0, or (rx_valid&rx_ready) in that same cycle: load rx_data and set rx_valid=1.
  - Otherwise: keep the old rx_data and rx_valid=1, pulse overrun, and drop the new byte.
- Handshake: rx_valid clears on the cycle after rx_valid&rx_ready, unless a delivery happens in the same cycle, in which case rx_valid stays 1 and rx_data updates. rx_data never changes while rx_valid=1 without an accept.
- Latency: the stop-bit sample occurs OVERSAMPLE/2 + 9*OVERSAMPLE = 152 ticks after start detection. At defaults, rx_valid rises 152*54 + 3 = 8211 cycles after the rx falling edge, ±1 cycle.
- Back-to-back frames: IDLE is re-entered mid stop bit, so a start edge arriving at the nominal end of the stop bit is detected. Baud mismatch up to ±3% must decode correctly.
- Glitch: a low pulse shorter than OVERSAMPLE/2 ticks is rejected as a false start.

Test Plan:
- After reset, drive bytes 8'h55, 8'hA3, 8'h0D at 115200 baud with rx_ready=1 → rx_data matches each byte. rx_valid is a one-cycle pulse per byte, about 8211 cycles after each start edge. frame_err and overrun stay 0.
- Send 8'h3C with rx_ready=0, then 8'hF0 → first byte held with rx_valid=1. On the 2nd stop sample, overrun pulses once. Raising rx_ready then yields rx_data=8'h3C, and rx_valid drops the next cycle.
- Send 8'h81 with the stop bit driven 0, then the line idle high → frame_err pulses exactly once and rx_valid stays 0. A following 8'h7E decodes correctly.
- Low glitch of 4 µs on the idle line → no rx_valid, no frame_err, and busy returns to 0 within about 8 ticks.
- Assert rst during bit 4 of 8'hC3 → outputs return to reset values. The next full frame 8'h12 decodes correctly.
- Run ten back-to-back 8'hFF/8'h00 frames at 113000 and 117500 baud with no idle gap → all bytes correct and no flags.
